packet_buffer_ctrl: RTL and testbench
=====================================

# packet_buffer_ctrl

Sensor-to-concentrator packet buffer controller. Shares the single write port of the packet RAM among `N_SENSORS` byte-stream requesters via round-robin arbitration. Tracks one packet slot per sensor. Drains completed slots one at a time onto a valid/ready output stream through the RAM's combinational read port. Sits between the sensor front-ends and the uplink framer.

## Interface
- `SENSOR_BITS`, default `` `log_sensors_number ``: sensor index width; `N_SENSORS = 2**SENSOR_BITS`.
- `BYTE_BITS`, default `` `log_packet_value ``: byte-in-packet index width; max packet = `2**BYTE_BITS` bytes.
- `DATA_WIDTH`, default 8: byte width.
- `ADDR_WIDTH`, derived: `SENSOR_BITS+BYTE_BITS`. RAM address = `{sensor, byte_idx}`.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `s_req` in N_SENSORS: sensor i has byte `s_data[i]` pending.
- `s_data` in N_SENSORS*DATA_WIDTH: flattened, sensor i at `[i*8 +: 8]`.
- `s_last` in N_SENSORS: pending byte closes the packet.
- `s_gnt` out N_SENSORS: one-hot or zero, combinational; byte consumed at this clock edge.
- `ram_we` out 1, `ram_waddr` out ADDR_WIDTH, `ram_wdata` out DATA_WIDTH: RAM write port.
- `ram_rd_en` out 1, `ram_raddr` out ADDR_WIDTH, `ram_q` in DATA_WIDTH: RAM read port (combinational read).
- `m_data` out DATA_WIDTH, `m_valid` out 1, `m_last` out 1, `m_sensor` out SENSOR_BITS, `m_ready` in 1: output stream.
- `slot_full` out N_SENSORS: slot i holds a closed packet awaiting drain.

## Operation
- Per-slot registers:
  - `wr_cnt[i]` (BYTE_BITS): next byte index.
  - `last_idx[i]` (BYTE_BITS).
  - `full[i]`.
- Write arbitration: eligible = `s_req & ~full`.
  - Round-robin from `wr_ptr`; winner i gets `s_gnt[i]=1`.
  - `ram_we=1`, `ram_waddr={i,wr_cnt[i]}`, `ram_wdata=s_data[i]`.
  - On the edge: `wr_ptr<=i+1` (mod N).
- Packet close: when granted with `s_last[i]=1` or `wr_cnt[i]==2**BYTE_BITS-1`, at the edge: `full[i]<=1`, `last_idx[i]<=wr_cnt[i]`, `wr_cnt[i]<=0`. Otherwise `wr_cnt[i]++`.
- Forced close at max count ignores the `s_last` value; the next byte from that sensor starts a new packet once the slot is drained.
- Requests into a full slot are never granted; the sensor stalls holding `s_req`.
- Reader FSM, states IDLE and SEND:
  - IDLE: `m_valid=0`, `ram_rd_en=0`. If `|full`, round-robin pick from `rd_ptr`; register `sel`, `rd_cnt<=0`, `rd_ptr<=sel+1`; go to SEND.
  - SEND: `ram_rd_en=1`, `ram_raddr={sel,rd_cnt}`, `m_valid=1`, `m_data=ram_q`, `m_sensor=sel`, `m_last=(rd_cnt==last_idx[sel])`.
  - On `m_valid&&m_ready`: `rd_cnt++`. If `m_last`: `full[sel]<=0`, go to IDLE.
- `m_data`, `m_last` and `m_sensor` are held stable while `m_valid && !m_ready`.
- No read/write hazard: only full slots are read, and full slots are never written.

## Timing
- Reset values: all counters, pointers and `full` = 0; FSM = IDLE; `m_valid`, `ram_rd_en` and `slot_full` = 0.
- With `s_req=0`: `s_gnt`, `ram_we`, `ram_waddr` and `ram_wdata` are 0.
- Throughput: one RAM write per cycle.
- Drain throughput: one byte per cycle under continuous `m_ready`, plus one IDLE cycle between packets.
- Latency: closing byte granted in cycle t → `slot_full` high in t+1 → first `m_valid` in t+2 (slot chosen in IDLE at the t+1 edge).
- Slot release: `full[sel]` clears at the edge accepting `m_last`; the sensor may be granted in the following cycle.
- Simultaneous events:
  - A write to slot A and a read of slot B in the same cycle are independent.
  - A slot closing in the same cycle another slot is chosen waits for the next IDLE visit.
- Reset mid-operation discards all buffered packets and the in-flight output (`m_valid` drops immediately). RAM contents are not cleared.

## Structure
- Shared header `concentrator_defs.vh`: `` `log_sensors_number ``, `` `log_packet_value ``, and the FSM state encodings (IDLE=0, SEND=1).
- Sub-module `rr_arbiter` (parameterized N; inputs `req`, `ptr`; outputs one-hot `gnt` plus encoded index). Instantiated twice: write grant and reader slot pick.
- The RAM is instantiated outside this block.

## Test plan
Configuration for all scenarios: SENSOR_BITS=2, BYTE_BITS=3.
- Single packet: sensor 1 sends 0xA0..0xA2 with `s_last` on 0xA2, `m_ready=1` → RAM writes at addresses 8, 9, 10; `m_valid` starts 2 cycles after the 0xA2 grant; output A0, A1, A2 with `m_last` on A2 and `m_sensor=1`.
- Fairness: sensors 0 and 3 both requesting continuously from reset → grants alternate 0, 3, 0, 3.
- Forced close: sensor 2 streams 9 bytes with no `s_last` → slot 2 closes after 8 bytes (`last_idx=7`); the 9th byte stalls until `m_last` is accepted, then is written at address 16.
- Backpressure: `m_ready` held low 5 cycles mid-packet → `m_data`, `m_last` and `m_valid` stable; no bytes lost or duplicated.
- Reader round-robin: slots 0 and 2 full simultaneously → slot 0 drained, one IDLE cycle, then slot 2.
- Async reset asserted mid-SEND → `m_valid` and `slot_full` go 0 without a clock; after release, new packets behave as in the single-packet scenario.

Source files
------------

// File: rtl/packet_buffer_ctrl_pkg.sv
// Shared definitions for the sensor packet buffer controller: default
// geometry and the reader FSM state encoding.
package packet_buffer_ctrl_pkg;

  // log2 of the number of sensors sharing the packet RAM
  localparam int LOG_SENSORS_NUMBER = 2;
  // log2 of the largest packet, in bytes
  localparam int LOG_PACKET_VALUE   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req starting at index ptr and wrapping,
// returns the first requester as a one-hot grant and as an encoded index.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [N-1:0]        gnt,
  output logic [IDX_BITS-1:0] idx
);

  logic                found;
  logic [IDX_BITS-1:0] cand;

  // Walk the requesters in rotated order and keep the first hit
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_BITS'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/packet_buffer_ctrl.sv
// Packet buffer controller: sensors share the RAM write port through a
// round-robin arbiter, each sensor owns one packet slot, and a reader FSM
// drains closed slots one at a time onto a valid/ready stream.
module packet_buffer_ctrl
  import packet_buffer_ctrl_pkg::*;
#(
  parameter  int SENSOR_BITS = LOG_SENSORS_NUMBER,
  parameter  int BYTE_BITS   = LOG_PACKET_VALUE,
  parameter  int DATA_WIDTH  = 8,
  localparam int N_SENSORS   = 2**SENSOR_BITS,
  localparam int ADDR_WIDTH  = SENSOR_BITS + BYTE_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_SENSORS-1:0]            s_req,
  input  logic [N_SENSORS*DATA_WIDTH-1:0] s_data,
  input  logic [N_SENSORS-1:0]            s_last,
  output logic [N_SENSORS-1:0]            s_gnt,
  output logic                            ram_we,
  output logic [ADDR_WIDTH-1:0]           ram_waddr,
  output logic [DATA_WIDTH-1:0]           ram_wdata,
  output logic                            ram_rd_en,
  output logic [ADDR_WIDTH-1:0]           ram_raddr,
  input  logic [DATA_WIDTH-1:0]           ram_q,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  output logic                            m_last,
  output logic [SENSOR_BITS-1:0]          m_sensor,
  input  logic                            m_ready,
  output logic [N_SENSORS-1:0]            slot_full
);

  // Per-slot bookkeeping
  logic [N_SENSORS-1:0]   full_reg;
  logic [BYTE_BITS-1:0]   wr_cnt_reg   [N_SENSORS];
  logic [BYTE_BITS-1:0]   last_idx_reg [N_SENSORS];
  logic [SENSOR_BITS-1:0] wr_ptr_reg;

  // Reader state
  rd_state_t              state_reg, state_next;
  logic [SENSOR_BITS-1:0] sel_reg;
  logic [SENSOR_BITS-1:0] rd_ptr_reg;
  logic [BYTE_BITS-1:0]   rd_cnt_reg;

  // Arbiter results
  logic [N_SENSORS-1:0]   wr_gnt, rd_gnt;
  logic [SENSOR_BITS-1:0] wr_idx, rd_idx;
  logic                   wr_any, rd_any;
  logic                   rd_done;

  // A full slot must never be written, so it is masked out of arbitration
  rr_arbiter #(.N(N_SENSORS), .IDX_BITS(SENSOR_BITS)) u_wr_arb (
    .req (s_req & ~full_reg),
    .ptr (wr_ptr_reg),
    .gnt (wr_gnt),
    .idx (wr_idx)
  );

  rr_arbiter #(.N(N_SENSORS), .IDX_BITS(SENSOR_BITS)) u_rd_arb (
    .req (full_reg),
    .ptr (rd_ptr_reg),
    .gnt (rd_gnt),
    .idx (rd_idx)
  );

  assign wr_any    = |wr_gnt;
  assign rd_any    = |rd_gnt;
  assign s_gnt     = wr_gnt;
  assign slot_full = full_reg;
  assign rd_done   = m_valid && m_ready && m_last;

  // Write port: zeroed whenever nothing is granted
  always_comb begin
    ram_we    = wr_any;
    ram_waddr = '0;
    ram_wdata = '0;
    if (wr_any) begin
      ram_waddr = {wr_idx, wr_cnt_reg[wr_idx]};
      ram_wdata = s_data[wr_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Write pointer moves past the last winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wr_ptr_reg <= '0;
    else if (wr_any) wr_ptr_reg <= wr_idx + 1'b1;
  end

  for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_slot
    // Slot fill/close on grant; release when its last byte is accepted
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_cnt_reg[gi]   <= '0;
        last_idx_reg[gi] <= '0;
        full_reg[gi]     <= 1'b0;
      end else if (wr_gnt[gi]) begin
        // A full-length packet closes regardless of s_last
        if (s_last[gi] || wr_cnt_reg[gi] == {BYTE_BITS{1'b1}}) begin
          full_reg[gi]     <= 1'b1;
          last_idx_reg[gi] <= wr_cnt_reg[gi];
          wr_cnt_reg[gi]   <= '0;
        end else begin
          wr_cnt_reg[gi]   <= wr_cnt_reg[gi] + 1'b1;
        end
      end else if (rd_done && sel_reg == SENSOR_BITS'(gi)) begin
        full_reg[gi] <= 1'b0;
      end
    end
  end

  // Reader FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Reader datapath: slot pick in IDLE, byte counter in SEND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_reg    <= '0;
      rd_ptr_reg <= '0;
      rd_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (rd_any) begin
        sel_reg    <= rd_idx;
        rd_cnt_reg <= '0;
        rd_ptr_reg <= rd_idx + 1'b1;
      end
    end else if (m_ready) begin
      rd_cnt_reg <= rd_cnt_reg + 1'b1;
    end
  end

  // Reader next state: one IDLE visit between packets
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rd_any)  state_next = SEND;
      SEND:    if (rd_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reader outputs: RAM address is held while stalled, so data stays stable
  always_comb begin
    m_valid   = 1'b0;
    ram_rd_en = 1'b0;
    ram_raddr = '0;
    m_data    = '0;
    m_sensor  = '0;
    m_last    = 1'b0;
    if (state_reg == SEND) begin
      m_valid   = 1'b1;
      ram_rd_en = 1'b1;
      ram_raddr = {sel_reg, rd_cnt_reg};
      m_data    = ram_q;
      m_sensor  = sel_reg;
      m_last    = (rd_cnt_reg == last_idx_reg[sel_reg]);
    end
  end

endmodule

// File: tb/tb_packet_buffer_ctrl.sv
// Bench for packet_buffer_ctrl: sensor byte queues drive the DUT, expected
// RAM writes and output beats are queued by the stimulus and checked by
// independent monitors.
module tb_packet_buffer_ctrl;

  localparam int SB = 2;
  localparam int BB = 3;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int AW = SB + BB;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NS-1:0]   s_req = '0;
  logic [NS*DW-1:0] s_data = '0;
  logic [NS-1:0]   s_last = '0;
  logic [NS-1:0]   s_gnt;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [DW-1:0]   ram_wdata;
  logic            ram_rd_en;
  logic [AW-1:0]   ram_raddr;
  logic [DW-1:0]   ram_q;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_last;
  logic [SB-1:0]   m_sensor;
  logic            m_ready = 1'b0;
  logic [NS-1:0]   slot_full;

  packet_buffer_ctrl #(.SENSOR_BITS(SB), .BYTE_BITS(BB), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .s_req(s_req), .s_data(s_data), .s_last(s_last),
    .s_gnt(s_gnt), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_rd_en(ram_rd_en), .ram_raddr(ram_raddr), .ram_q(ram_q),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_sensor(m_sensor),
    .m_ready(m_ready), .slot_full(slot_full)
  );

  always #5 clk = ~clk;

  // External packet RAM: synchronous write, combinational read
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
  assign ram_q = mem[ram_raddr];

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [DW-1:0] data; logic last; logic [SB-1:0] sensor; } beat_t;

  wr_t   wr_exp[$];
  beat_t out_exp[$];
  wr_t   wr_act, wr_e;
  beat_t out_act, out_e;

  int tests = 0, fails = 0, cyc = 0, acc_cnt = 0;
  int last_wr_cyc = 0, valid_rise_cyc = 0, last_mlast_cyc = 0, rise_gap = 0;
  logic prev_valid = 1'b0;
  logic [NS-1:0] drv_g;

  logic [8:0] sbuf [NS][16];
  int shead [NS];
  int stail [NS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_sensors();
    for (int i = 0; i < NS; i++) begin
      if (shead[i] < stail[i]) begin
        s_req[i]          = 1'b1;
        s_data[i*DW +: DW] = sbuf[i][shead[i]][7:0];
        s_last[i]         = sbuf[i][shead[i]][8];
      end else begin
        s_req[i]          = 1'b0;
        s_data[i*DW +: DW] = '0;
        s_last[i]         = 1'b0;
      end
    end
  endtask

  function automatic bit sensors_pending();
    for (int i = 0; i < NS; i++) if (shead[i] < stail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input int s, input logic [7:0] d, input logic l);
    sbuf[s][stail[s]] = {l, d};
    stail[s]++;
    drive_sensors();
  endtask

  task automatic clear_bench();
    wr_exp.delete();
    out_exp.delete();
    for (int i = 0; i < NS; i++) begin
      shead[i] = 0;
      stail[i] = 0;
    end
    drive_sensors();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    clear_bench();
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int  n;
    bit  timed_out;
    n = 0;
    timed_out = 1'b0;
    while (wr_exp.size() != 0 || out_exp.size() != 0 || sensors_pending()) begin
      if (n >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    check({name, "_timeout"}, 32'(timed_out), 32'd0);
    check({name, "_slot_full_idle"}, 32'({slot_full, m_valid}), 32'd0);
  endtask

  task automatic single_packet(input logic [7:0] base);
    logic [7:0] b1, b2;
    b1 = base + 8'd1;
    b2 = base + 8'd2;
    m_ready = 1'b1;
    wr_exp.push_back(wr_t'({5'd8,  base}));
    wr_exp.push_back(wr_t'({5'd9,  b1}));
    wr_exp.push_back(wr_t'({5'd10, b2}));
    out_exp.push_back(beat_t'({base, 1'b0, 2'd1}));
    out_exp.push_back(beat_t'({b1,   1'b0, 2'd1}));
    out_exp.push_back(beat_t'({b2,   1'b1, 2'd1}));
    push(1, base, 1'b0);
    push(1, b1,   1'b0);
    push(1, b2,   1'b1);
    wait_drain("single", 50);
    check("single_latency", 32'(valid_rise_cyc - last_wr_cyc), 32'd2);
  endtask

  // Cycle counter used for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor
  always @(negedge clk) begin
    if (!rst && ram_we) begin
      wr_act      = {ram_waddr, ram_wdata};
      last_wr_cyc = cyc;
      $display("[TB] cyc %0d write addr=%0d data=%02h", cyc, ram_waddr, ram_wdata);
      if (wr_exp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: got addr=%0d data=%02h expected no write", ram_waddr, ram_wdata);
      end else begin
        wr_e = wr_exp.pop_front();
        check("wr", 32'(wr_act), 32'(wr_e));
      end
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (m_valid && !prev_valid) begin
        valid_rise_cyc = cyc;
        rise_gap       = cyc - last_mlast_cyc;
      end
      prev_valid = m_valid;
      if (m_valid && m_ready) begin
        out_act = {m_data, m_last, m_sensor};
        acc_cnt++;
        $display("[TB] cyc %0d out sensor=%0d data=%02h last=%0d", cyc, m_sensor, m_data, m_last);
        if (out_exp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_unexpected: got data=%02h last=%0d sensor=%0d expected no beat", m_data, m_last, m_sensor);
        end else begin
          out_e = out_exp.pop_front();
          check("out_beat", 32'(out_act), 32'(out_e));
        end
        if (m_last) last_mlast_cyc = cyc;
      end
    end
  end

  // Sensor model: a byte granted before an edge is removed after it
  initial begin
    for (int i = 0; i < NS; i++) begin
      shead[i] = 0;
      stail[i] = 0;
    end
    forever begin
      @(negedge clk);
      drv_g = s_gnt;
      @(posedge clk); #1;
      for (int i = 0; i < NS; i++)
        if (drv_g[i] && shead[i] < stail[i]) shead[i]++;
      drive_sensors();
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;

    // Reset state with idle sensors
    repeat (2) @(posedge clk);
    #2;
    check("rst_outputs", 32'({s_gnt, ram_we, m_valid, ram_rd_en, slot_full}), 32'd0);
    check("rst_wport",   32'({ram_waddr, ram_wdata}), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_outputs", 32'({s_gnt, ram_we, ram_waddr, ram_wdata, m_valid, slot_full}), 32'd0);

    // Single packet from sensor 1
    single_packet(8'hA0);

    // Fairness: sensors 0 and 3 request together from reset
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_exp.push_back(wr_t'({2'd0, 3'(k), 8'(8'h10 + k)}));
      wr_exp.push_back(wr_t'({2'd3, 3'(k), 8'(8'h30 + k)}));
    end
    for (int k = 0; k < 4; k++) out_exp.push_back(beat_t'({8'(8'h10 + k), (k == 3), 2'd0}));
    for (int k = 0; k < 4; k++) out_exp.push_back(beat_t'({8'(8'h30 + k), (k == 3), 2'd3}));
    for (int k = 0; k < 4; k++) begin
      push(0, 8'(8'h10 + k), (k == 3));
      push(3, 8'(8'h30 + k), (k == 3));
    end
    wait_drain("fair", 60);
    check("fair_idle_gap", 32'(rise_gap), 32'd2);

    // Forced close after 8 bytes; 9th byte waits for the drain
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wr_exp.push_back(wr_t'({5'(16 + k), 8'(8'h50 + k)}));
      out_exp.push_back(beat_t'({8'(8'h50 + k), (k == 7), 2'd2}));
    end
    wr_exp.push_back(wr_t'({5'd16, 8'h58}));
    for (int k = 0; k < 9; k++) push(2, 8'(8'h50 + k), 1'b0);
    wait_drain("forced", 80);
    check("forced_reuse_cycle", 32'(last_wr_cyc - last_mlast_cyc), 32'd1);

    // Backpressure mid-packet
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_exp.push_back(wr_t'({5'(8 + k), 8'(8'h70 + k)}));
      out_exp.push_back(beat_t'({8'(8'h70 + k), (k == 3), 2'd1}));
      push(1, 8'(8'h70 + k), (k == 3));
    end
    base = acc_cnt;
    n = 0;
    while (acc_cnt < base + 2 && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    check("bp_reach_timeout", 32'(n >= 40), 32'd0);
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", 32'({m_valid, m_last, m_sensor, m_data}), 32'({1'b1, 1'b0, 2'd1, 8'h72}));
    end
    @(posedge clk); #2;
    m_ready = 1'b1;
    wait_drain("bp", 40);

    // Reader round-robin: slots 0 and 2 close while slot 3 is stalled
    do_reset();
    m_ready = 1'b0;
    wr_exp.push_back(wr_t'({5'd24, 8'h33}));
    out_exp.push_back(beat_t'({8'h33, 1'b1, 2'd3}));
    push(3, 8'h33, 1'b1);
    repeat (4) begin
      @(posedge clk); #2;
    end
    wr_exp.push_back(wr_t'({5'd0,  8'h40}));
    wr_exp.push_back(wr_t'({5'd16, 8'h42}));
    out_exp.push_back(beat_t'({8'h40, 1'b1, 2'd0}));
    out_exp.push_back(beat_t'({8'h42, 1'b1, 2'd2}));
    push(0, 8'h40, 1'b1);
    push(2, 8'h42, 1'b1);
    repeat (4) begin
      @(posedge clk); #2;
    end
    check("rr_all_full", 32'(slot_full), 32'(4'b1101));
    m_ready = 1'b1;
    wait_drain("rr", 40);
    check("rr_idle_gap", 32'(rise_gap), 32'd2);

    // Asynchronous reset while a packet is being presented
    do_reset();
    m_ready = 1'b0;
    wr_exp.push_back(wr_t'({5'd8,  8'hB0}));
    wr_exp.push_back(wr_t'({5'd9,  8'hB1}));
    wr_exp.push_back(wr_t'({5'd10, 8'hB2}));
    push(1, 8'hB0, 1'b0);
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b1);
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_valid_before", 32'({m_valid, slot_full}), 32'({1'b1, 4'b0010}));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("ar_async_drop", 32'({m_valid, ram_rd_en, slot_full}), 32'd0);
    clear_bench();
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    single_packet(8'hC0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
